spart_echo_ctrl: RTL and testbench

Bus controller for the SPART serial port on the processor-side I/O bus. After reset it programs the baud divisor selected by `br_cfg`, then services the port: it reads received bytes into a small echo FIFO whenever `rda` is set, and writes them back out whenever `tbr` is set. When both are ready, the two kinds of access share the single I/O bus round-robin. It replaces the testbench driver as the synthesizable master in the loopback build.

---
 rtl/spart_pkg.sv | 22 ++
 rtl/spart_echo_fifo.sv | 55 +++++
 rtl/spart_echo_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spart_echo_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus controller: FSM states,
// I/O register addresses and the baud divisor table (50 MHz clock).
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GAP
    } spart_ctrl_state_t;

    localparam logic [1:0] IOA_BUF  = 2'b00;
    localparam logic [1:0] IOA_STAT = 2'b01;
    localparam logic [1:0] IOA_DBL  = 2'b10;
    localparam logic [1:0] IOA_DBH  = 2'b11;

    // Indexed by br_cfg: 4800, 9600, 19200, 38400 baud.
    localparam logic [15:0] BR_DIVISOR [4] = '{16'd650, 16'd325, 16'd162, 16'd80};

endpackage

// File: rtl/spart_echo_fifo.sv
// Byte FIFO buffering received characters until they can be echoed.
// DEPTH must be a power of 2 so the pointers wrap for free.
module spart_echo_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    output logic [7:0]               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/spart_echo_ctrl.sv
// SPART bus master: programs the baud divisor, then echoes RX bytes to TX
// through a small FIFO with round-robin bus sharing. Optional: BR_RECONFIG_EN.
module spart_echo_ctrl
    import spart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  wire  [7:0]                    databus,
    output logic                          cfg_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    spart_ctrl_state_t r_state;
    spart_ctrl_state_t w_next;
    spart_ctrl_state_t w_sched;

    logic          r_run;
    logic          r_cfg_busy;
    logic          r_last_wr;
    logic [GW-1:0] r_gap_cnt;
    logic [1:0]    r_br_cur;
    logic [1:0]    w_br_src;
    logic          w_reconfig;
    logic [15:0]   w_div_new;
    logic [15:0]   w_div_cur;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_fifo_dout;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_dout;

`ifdef BR_RECONFIG_EN
    logic [1:0] r_br_s1;
    logic [1:0] r_br_s2;

    // br_cfg is assumed static across reset release, so both stages preload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_s1 <= 2'b00;
            r_br_s2 <= 2'b00;
        end else if (!r_run) begin
            r_br_s1 <= br_cfg;
            r_br_s2 <= br_cfg;
        end else begin
            r_br_s1 <= br_cfg;
            r_br_s2 <= r_br_s1;
        end
    end

    assign w_br_src   = r_br_s2;
    assign w_reconfig = (r_br_s2 != r_br_cur);
`else
    assign w_br_src   = br_cfg;
    assign w_reconfig = 1'b0;
`endif

    assign w_div_new = BR_DIVISOR[w_br_src];
    assign w_div_cur = BR_DIVISOR[r_br_cur];

    // Round-robin: on a tie the side not granted last wins.
    assign w_rd_ok = rda && !w_full;
    assign w_wr_ok = tbr && !w_empty;

    always_comb begin
        w_sched = IDLE;
        if (w_reconfig)                        w_sched = CFG_LO;
        else if (w_rd_ok && (!w_wr_ok || r_last_wr)) w_sched = RD;
        else if (w_wr_ok)                      w_sched = WR;
    end

    // The last GAP cycle arbitrates directly so the access period is 1+GAP_CYCLES.
    always_comb begin
        w_next = r_state;
        case (r_state)
            CFG_LO:  w_next = CFG_HI;
            CFG_HI:  w_next = GAP;
            IDLE:    w_next = w_sched;
            RD:      w_next = GAP;
            WR:      w_next = GAP;
            GAP:     if (r_gap_cnt == '0) w_next = w_sched;
            default: w_next = CFG_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_state    <= CFG_LO;
            r_cfg_busy <= 1'b1;
            r_last_wr  <= 1'b1;
            r_gap_cnt  <= '0;
            r_br_cur   <= 2'b00;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_state <= w_next;
                if (w_next == GAP && r_state != GAP)
                    r_gap_cnt <= GW'(GAP_CYCLES - 1);
                else if (r_state == GAP && r_gap_cnt != '0)
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                if (r_state == CFG_LO)
                    r_br_cur <= w_br_src;
                if (w_next == CFG_LO)
                    r_cfg_busy <= 1'b1;
                else if (r_state == CFG_HI)
                    r_cfg_busy <= 1'b0;
                if (w_next == RD)
                    r_last_wr <= 1'b0;
                else if (w_next == WR)
                    r_last_wr <= 1'b1;
            end
        end
    end

    // Bus outputs stay idle until the first edge after reset release.
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = IOA_BUF;
        w_dout = 8'h00;
        if (r_run) begin
            case (r_state)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = IOA_DBL;
                    w_dout = w_div_new[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = IOA_DBH;
                    w_dout = w_div_cur[15:8];
                end
                RD: begin
                    iocs = 1'b1;
                end
                WR: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    w_dout = w_fifo_dout;
                end
                default: ;
            endcase
        end
    end

    assign databus  = (iocs && !iorw) ? w_dout : 8'bzzzz_zzzz;
    assign cfg_busy = r_cfg_busy;
    assign w_push   = r_run && (r_state == RD);
    assign w_pop    = r_run && (r_state == WR);

    spart_echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (databus),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (fifo_cnt)
    );

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Bench for spart_echo_ctrl: behavioural SPART model plus an echo queue model.
module tb_spart_echo_ctrl;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       tbr;
    logic       rda_r;
    logic [7:0] rx_head;
    logic       iocs, iorw, cfg_busy;
    logic [1:0] ioaddr;
    logic [2:0] fifo_cnt;
    wire  [7:0] databus;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_echo = 0;
    int n_push = 0;
    int last_acc = -100;

    logic [7:0] rx_q[$];   // bytes waiting in the SPART receiver
    logic [7:0] exp_q[$];  // bytes expected to sit in the echo FIFO
    logic       pend_rd = 1'b0, pend_wr = 1'b0;

    spart_echo_ctrl #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .rda      (rda_r),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .cfg_busy (cfg_busy),
        .fifo_cnt (fifo_cnt)
    );

    assign databus = (iocs && iorw) ? rx_head : 8'bzzzz_zzzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: retire the access that closed at the last edge, then observe this cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            pend_rd  = 1'b0;
            pend_wr  = 1'b0;
            last_acc = -100;
        end else begin
            if (pend_rd && rx_q.size() > 0) exp_q.push_back(rx_q.pop_front());
            if (pend_wr) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_echo++;
            end
            pend_rd = 1'b0;
            pend_wr = 1'b0;
            chk("fifo_cnt", 16'(fifo_cnt), 16'(exp_q.size()));
            if (iocs && ioaddr == 2'b00) begin
                chk("acc_spacing", 16'((cyc - last_acc) >= GAP + 1), 16'd1);
                if (iorw) begin
                    chk("rd_not_full", 16'(exp_q.size() < DEPTH), 16'd1);
                    chk("rd_rda", 16'(rx_q.size() > 0), 16'd1);
                    pend_rd = 1'b1;
                end else begin
                    chk("wr_not_empty", 16'(exp_q.size() > 0), 16'd1);
                    if (exp_q.size() > 0) chk("echo_data", 16'(databus), 16'(exp_q[0]));
                    pend_wr = 1'b1;
                end
            end
            if (iocs) last_acc = cyc;
            else chk("bus_z", 16'(databus === 8'bzzzz_zzzz), 16'd1);
        end
        rda_r   = (rx_q.size() > 0);
        rx_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    task automatic push_b(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_q.push_back(b);
    endtask

    task automatic wait_acc(output logic rw, output logic [1:0] a, output logic [7:0] d, output int c);
        logic ok = 1'b0;
        rw = 1'b1; a = 2'b00; d = 8'h00; c = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (iocs) begin
                ok = 1'b1; rw = iorw; a = ioaddr; d = databus; c = cyc;
            end
        end
        chk("acc_seen", 16'(ok), 16'd1);
    endtask

    task automatic wait_wr(output logic [7:0] d);
        logic ok = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (iocs && !iorw && ioaddr == 2'b00) begin
                ok = 1'b1; d = databus;
            end
        end
        chk("wr_seen", 16'(ok), 16'd1);
    endtask

    task automatic wait_cnt(input int n);
        logic ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (fifo_cnt == 3'(n));
        end
        chk("cnt_reached", 16'(ok), 16'd1);
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = (rx_q.size() == 0) && (exp_q.size() == 0) && !iocs;
        end
        chk("drained", 16'(ok), 16'd1);
    endtask

    initial begin
        logic       rw;
        logic [1:0] a;
        logic [7:0] d;
        int         c, c0, e0;

        rst = 1'b0; br_cfg = 2'b01; tbr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_iocs", 16'(iocs), 16'd0);
        chk("rst_iorw", 16'(iorw), 16'd1);
        chk("rst_ioaddr", 16'(ioaddr), 16'd0);
        chk("rst_bus_z", 16'(databus === 8'bzzzz_zzzz), 16'd1);
        chk("rst_cfg_busy", 16'(cfg_busy), 16'd1);
        chk("rst_fifo_cnt", 16'(fifo_cnt), 16'd0);
        rst = 1'b1;

        // Divisor programming for br_cfg=01 (325 = 0x0145)
        wait_acc(rw, a, d, c0);
        chk("cfg_lo", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b10, 8'h45});
        wait_acc(rw, a, d, c);
        chk("cfg_hi", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b11, 8'h01});
        chk("cfg_consecutive", 16'(c - c0), 16'd1);
        chk("cfg_busy_hi", 16'(cfg_busy), 16'd1);
        @(negedge clk);
        chk("cfg_busy_fall", 16'(cfg_busy), 16'd0);

        // Single byte echo: RD, one GAP, WR
        tbr = 1'b1;
        push_b(8'h5A);
        wait_acc(rw, a, d, c0);
        chk("t2_rd", {5'd0, rw, a, d}, {5'd0, 1'b1, 2'b00, 8'h5A});
        @(negedge clk);
        chk("t2_cnt1", 16'(fifo_cnt), 16'd1);
        wait_acc(rw, a, d, c);
        chk("t2_wr", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b00, 8'h5A});
        chk("t2_latency", 16'(c - c0), 16'(1 + GAP));
        @(negedge clk);
        chk("t2_cnt0", 16'(fifo_cnt), 16'd0);

        // Full FIFO holds off the fifth read
        tbr = 1'b0;
        for (int k = 1; k <= 5; k++) push_b(8'(k));
        repeat (30) @(negedge clk);
        chk("t3_full_cnt", 16'(fifo_cnt), 16'(DEPTH));
        chk("t3_held", 16'(rx_q.size()), 16'd1);
        tbr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_wr(d);
            chk("t3_order", 16'(d), 16'(k));
        end
        wait_idle();

        // Continuous rda and tbr: strict alternation, one GAP apart
        tbr = 1'b0;
        for (int k = 0; k < 8; k++) push_b(8'h80 + 8'(k));
        wait_cnt(DEPTH);
        tbr = 1'b1;
        c0 = 0;
        for (int k = 0; k < 6; k++) begin
            wait_acc(rw, a, d, c);
            chk("t4_alt", 16'(rw), 16'(k % 2));
            if (k > 0) chk("t4_period", 16'(c - c0), 16'(1 + GAP));
            c0 = c;
        end
        wait_idle();

        // Reset in the middle of a WR
        tbr = 1'b0;
        push_b(8'hA1);
        push_b(8'hA2);
        wait_cnt(2);
        tbr = 1'b1;
        wait_acc(rw, a, d, c);
        chk("t5_is_wr", 16'(rw), 16'd0);
        #2 rst = 1'b0;
        #1;
        chk("t5_iocs", 16'(iocs), 16'd0);
        chk("t5_bus_z", 16'(databus === 8'bzzzz_zzzz), 16'd1);
        chk("t5_cnt", 16'(fifo_cnt), 16'd0);
        chk("t5_busy", 16'(cfg_busy), 16'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_acc(rw, a, d, c);
        chk("t5_cfg_lo", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b10, 8'h45});
        wait_acc(rw, a, d, c);
        chk("t5_cfg_hi", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b11, 8'h01});
        @(negedge clk);
        chk("t5_cnt_after", 16'(fifo_cnt), 16'd0);

`ifdef BR_RECONFIG_EN
        // Live divisor change with buffered data (80 = 0x0050)
        tbr = 1'b0;
        push_b(8'hC3);
        push_b(8'h3C);
        wait_cnt(2);
        br_cfg = 2'b11;
        wait_acc(rw, a, d, c);
        chk("rc_cfg_lo", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b10, 8'h50});
        wait_acc(rw, a, d, c);
        chk("rc_cfg_hi", {5'd0, rw, a, d}, {5'd0, 1'b0, 2'b11, 8'h00});
        tbr = 1'b1;
        wait_wr(d);
        chk("rc_echo0", 16'(d), 16'h00C3);
        wait_wr(d);
        chk("rc_echo1", 16'(d), 16'h003C);
        wait_idle();
`endif

        // Random traffic against the queue model
        e0 = n_echo;
        n_push = 0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            tbr = ($urandom_range(0, 9) < 7);
            if (rx_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                rx_q.push_back(8'($urandom));
                n_push++;
            end
        end
        tbr = 1'b1;
        wait_idle();
        chk("rand_echo_count", 16'(n_echo - e0), 16'(n_push));
        chk("rand_cnt_final", 16'(fifo_cnt), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
